axis_avst_tx_arb: RTL and testbench

Packet-granular round-robin arbiter that merges PORTS AXI-stream sources onto one Avalon-ST sink, such as a MAC TX interface. It holds each grant from the first beat to tlast and generates startofpacket, endofpacket, empty and error. The output is registered through a 2-entry skid buffer, so throughput is full and avst_ready has no combinational path to any s_axis_tready. It sits between the per-queue TX datapaths and the vendor MAC Avalon-ST port.

---
 rtl/axis_avst_tx_arb_if.sv | 40 ++++
 rtl/axis_avst_tx_arb.sv | 160 ++++++++++++++++
 tb/tb_axis_avst_tx_arb.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_avst_tx_arb_if.sv
// Stream bundle between the TX queue sources and the Avalon-ST MAC port.
// slave = arbiter side, master = source/sink side.
interface axis_avst_tx_arb_if #(
    parameter int PORTS       = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int EMPTY_WIDTH = $clog2(KEEP_WIDTH),
    parameter int GRANT_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1
);
    logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [PORTS-1:0]            s_axis_tvalid;
    logic [PORTS-1:0]            s_axis_tready;
    logic [PORTS-1:0]            s_axis_tlast;
    logic [PORTS-1:0]            s_axis_tuser;
    logic                        avst_ready;
    logic                        avst_valid;
    logic [DATA_WIDTH-1:0]       avst_data;
    logic                        avst_startofpacket;
    logic                        avst_endofpacket;
    logic [EMPTY_WIDTH-1:0]      avst_empty;
    logic                        avst_error;
    logic [GRANT_WIDTH-1:0]      grant_port;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid,
        input  s_axis_tlast, s_axis_tuser, avst_ready,
        output s_axis_tready, avst_valid, avst_data,
        output avst_startofpacket, avst_endofpacket,
        output avst_empty, avst_error, grant_port
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid,
        output s_axis_tlast, s_axis_tuser, avst_ready,
        input  s_axis_tready, avst_valid, avst_data,
        input  avst_startofpacket, avst_endofpacket,
        input  avst_empty, avst_error, grant_port
    );
endinterface

// File: rtl/axis_avst_tx_arb.sv
// Packet-granular round-robin merge of AXI-stream sources onto one
// Avalon-ST sink, with a 2-entry skid buffer on the output.
module axis_avst_tx_arb #(
    parameter int PORTS        = 2,
    parameter int DATA_WIDTH   = 64,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int EMPTY_WIDTH  = $clog2(KEEP_WIDTH),
    parameter bit BYTE_REVERSE = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    axis_avst_tx_arb_if.slave  bus
);
    localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
        logic                   error;
    } beat_t;

    typedef enum logic {S_IDLE, S_PACKET} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   sel, grant;
    logic            accept_q, accept_d;
    logic            out_vld_q, out_vld_d;
    logic            tmp_vld_q, tmp_vld_d;
    beat_t           out_q, out_d;
    beat_t           tmp_q, tmp_d;
    beat_t           in_beat;
    logic            any_vld, xfer_in, xfer_out;
    logic            in_last, in_user;
    logic [PORTS-1:0]      tready;
    logic [KEEP_WIDTH-1:0] in_keep;
    logic [DATA_WIDTH-1:0] in_data;
    logic [2*PORTS-1:0]    vv;

    // Rotate valids so bit 0 is rr_q; lowest set bit wins.
    always_comb begin : p_sel
        int idx;
        idx     = 0;
        sel     = rr_q;
        any_vld = |bus.s_axis_tvalid;
        vv      = {bus.s_axis_tvalid, bus.s_axis_tvalid} >> rr_q;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (vv[k]) begin
                idx = int'(rr_q) + k;
                if (idx >= PORTS) idx = idx - PORTS;
                sel = GW'(idx);
            end
        end
    end

    always_comb begin : p_grant
        grant   = (state_q == S_IDLE && any_vld) ? sel : grant_q;
        tready  = '0;
        in_data = '0;
        in_keep = '0;
        in_last = 1'b0;
        in_user = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant == GW'(i)) begin
                tready[i] = accept_q & ((state_q == S_PACKET) | any_vld);
                in_data   = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                in_keep   = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                in_last   = bus.s_axis_tlast[i];
                in_user   = bus.s_axis_tuser[i];
            end
        end
        xfer_in = |(tready & bus.s_axis_tvalid);
    end

    always_comb begin : p_beat
        int ones;
        ones    = 0;
        in_beat = '0;
        for (int b = 0; b < KEEP_WIDTH; b++) ones = ones + int'(in_keep[b]);
        in_beat.data = in_data;
        if (BYTE_REVERSE) begin
            for (int b = 0; b < KEEP_WIDTH; b++)
                in_beat.data[b*8 +: 8] = in_data[(KEEP_WIDTH-1-b)*8 +: 8];
        end
        in_beat.sop   = (state_q == S_IDLE);
        in_beat.eop   = in_last;
        in_beat.empty = in_last ? EMPTY_WIDTH'(KEEP_WIDTH - ones) : '0;
        in_beat.error = in_user & in_last;
    end

    always_comb begin : p_next
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        tmp_d     = tmp_q;
        tmp_vld_d = tmp_vld_q;
        xfer_out  = out_vld_q & bus.avst_ready;
        if (xfer_in) begin
            if (in_last) begin
                state_d = S_IDLE;
                rr_d    = (grant == GW'(PORTS - 1)) ? '0 : grant + GW'(1);
            end else begin
                state_d = S_PACKET;
            end
        end
        // temp only fills while the output holds; it drains first.
        if (!out_vld_q || xfer_out) begin
            if (tmp_vld_q) begin
                out_d     = tmp_q;
                out_vld_d = 1'b1;
                tmp_vld_d = 1'b0;
            end else if (xfer_in) begin
                out_d     = in_beat;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (xfer_in) begin
            tmp_d     = in_beat;
            tmp_vld_d = 1'b1;
        end
        accept_d = ~tmp_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            accept_q  <= 1'b0;
            out_vld_q <= 1'b0;
            tmp_vld_q <= 1'b0;
            out_q     <= '0;
            tmp_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            accept_q  <= accept_d;
            out_vld_q <= out_vld_d;
            tmp_vld_q <= tmp_vld_d;
            out_q     <= out_d;
            tmp_q     <= tmp_d;
        end
    end

    assign bus.s_axis_tready      = tready;
    assign bus.avst_valid         = out_vld_q;
    assign bus.avst_data          = out_q.data;
    assign bus.avst_startofpacket = out_q.sop;
    assign bus.avst_endofpacket   = out_q.eop;
    assign bus.avst_empty         = out_q.empty;
    assign bus.avst_error         = out_q.error;
    assign bus.grant_port         = grant_q;
endmodule

// File: tb/tb_axis_avst_tx_arb.sv
// Bench for axis_avst_tx_arb: packet-level scoreboard plus directed
// sequences and a vector table of single-beat sideband cases.
module tb_axis_avst_tx_arb;
    localparam int P  = 2;
    localparam int DW = 64;
    localparam int KW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_avst_tx_arb_if #(.PORTS(P), .DATA_WIDTH(DW)) bus ();

    axis_avst_tx_arb #(.PORTS(P), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } in_t;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        err;
        int          port;
    } ob_t;

    typedef struct {
        int          port;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        user;
        logic [2:0]  x_empty;
        logic        x_err;
    } vec_t;

    in_t  src [P][$];
    ob_t  exp_q[$];
    ob_t  obs[$];
    int   sop_ports[$];
    vec_t tbl [7];

    int   pass_n = 0;
    int   total_n = 0;
    int   rdy_prob = 100;
    int   vld_prob = 100;
    bit   in_pkt = 0;
    int   cur = 0;
    int   rr = 0;
    bit   took [P];
    bit   chk_grant = 0;
    bit   prev_stall = 0;
    logic [70:0] snap;
    int   cyc = 0;
    int   first_acc = 0;
    int   last_acc = 0;
    bit   any_acc = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Round-robin choice from the rules: first valid at or after rr.
    function automatic int rr_pick(input logic [P-1:0] tv);
        for (int k = 0; k < P; k++) begin
            int idx;
            idx = (rr + k) % P;
            if (tv[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic monitor();
        ob_t e;
        in_t b;
        int nacc;
        int ap;
        logic [P-1:0] m;
        logic [70:0] now;
        nacc = 0;
        ap = -1;
        cyc++;
        now = {bus.avst_valid, bus.avst_data, bus.avst_startofpacket,
               bus.avst_endofpacket, bus.avst_empty, bus.avst_error};
        if (prev_stall) chk("hold_stable", now, snap);
        if (exp_q.size() > 0) chk("pending_valid", bus.avst_valid, 1'b1);
        if (bus.avst_valid && bus.avst_ready) begin
            chk("out_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_beat",
                    {bus.avst_data, bus.avst_startofpacket,
                     bus.avst_endofpacket, bus.avst_empty, bus.avst_error},
                    {e.data, e.sop, e.eop, e.empty, e.err});
                obs.push_back(e);
                if (bus.avst_startofpacket) begin
                    sop_ports.push_back(e.port);
                    if (chk_grant) chk("grant_port", bus.grant_port, e.port);
                end
            end
        end
        for (int i = 0; i < P; i++)
            if (bus.s_axis_tvalid[i] && bus.s_axis_tready[i]) begin
                nacc++;
                ap = i;
            end
        if (in_pkt) begin
            m = bus.s_axis_tready;
            m[cur] = 1'b0;
            chk("tready_excl", m, '0);
        end
        if (nacc > 0) chk("one_accept", nacc, 1);
        if (nacc == 1) begin
            if (in_pkt) chk("same_port", ap, cur);
            else chk("rr_pick", ap, rr_pick(bus.s_axis_tvalid));
            b = src[ap][0];
            e.data  = b.data;
            e.sop   = !in_pkt;
            e.eop   = b.last;
            e.empty = b.last ? 3'(KW - $countones(b.keep)) : 3'd0;
            e.err   = b.user & b.last;
            e.port  = ap;
            exp_q.push_back(e);
            took[ap] = 1'b1;
            if (b.last) begin
                in_pkt = 1'b0;
                rr = (ap + 1) % P;
            end else begin
                in_pkt = 1'b1;
                cur = ap;
            end
            if (!any_acc) first_acc = cyc;
            any_acc = 1'b1;
            last_acc = cyc;
        end
        chk("occupancy", exp_q.size() <= 2, 1'b1);
        prev_stall = bus.avst_valid && !bus.avst_ready;
        snap = now;
    endtask

    task automatic drive();
        for (int i = 0; i < P; i++) begin
            if (took[i]) begin
                void'(src[i].pop_front());
                took[i] = 1'b0;
                bus.s_axis_tvalid[i] = 1'b0;
            end
            if (!bus.s_axis_tvalid[i] && src[i].size() > 0 &&
                $urandom_range(99) < vld_prob) begin
                bus.s_axis_tvalid[i] = 1'b1;
                bus.s_axis_tdata[i*DW +: DW] = src[i][0].data;
                bus.s_axis_tkeep[i*KW +: KW] = src[i][0].keep;
                bus.s_axis_tlast[i] = src[i][0].last;
                bus.s_axis_tuser[i] = src[i][0].user;
            end
        end
        bus.avst_ready = ($urandom_range(99) < rdy_prob);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit idle();
        for (int i = 0; i < P; i++) if (src[i].size() > 0) return 1'b0;
        return exp_q.size() == 0;
    endfunction

    task automatic run(input int budget);
        int n;
        n = 0;
        while (!idle() && n < budget) begin
            step();
            n++;
        end
        if (!idle()) begin
            total_n++;
            $display("FAIL drain_timeout: pending %0d beats after %0d cycles",
                     exp_q.size(), n);
        end
    endtask

    task automatic add_beat(input int p, input logic [63:0] d,
                            input logic [7:0] k, input logic l,
                            input logic u);
        in_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        b.user = u;
        src[p].push_back(b);
    endtask

    task automatic add_pkt(input int p, input int len,
                           input logic [63:0] base, input logic [7:0] lkeep,
                           input logic u);
        for (int k = 0; k < len; k++)
            add_beat(p, base + 64'(k), (k == len - 1) ? lkeep : 8'hFF,
                     k == len - 1, u);
    endtask

    task automatic clear_model();
        for (int i = 0; i < P; i++) begin
            src[i].delete();
            took[i] = 1'b0;
        end
        exp_q.delete();
        in_pkt = 1'b0;
        rr = 0;
        prev_stall = 1'b0;
        bus.s_axis_tvalid = '0;
    endtask

    initial begin
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tuser  = '0;
        bus.avst_ready    = 1'b0;
        for (int i = 0; i < P; i++) took[i] = 1'b0;

        tbl[0] = '{0, 64'hA5A5_A5A5_0000_0001, 8'hFF, 1'b0, 3'd0, 1'b0};
        tbl[1] = '{1, 64'h0000_0000_0000_00C3, 8'h01, 1'b0, 3'd7, 1'b0};
        tbl[2] = '{0, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b1, 3'd4, 1'b1};
        tbl[3] = '{1, 64'h0012_3456_789A_BCDE, 8'h7F, 1'b0, 3'd1, 1'b0};
        tbl[4] = '{0, 64'h5555_AAAA_5555_AAAA, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[5] = '{1, 64'h0000_0000_0000_BEEF, 8'h03, 1'b1, 3'd6, 1'b1};
        tbl[6] = '{0, 64'h0000_CAFE_F00D_1234, 8'h3F, 1'b0, 3'd2, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.avst_valid, 1'b0);
        chk("rst_sop", bus.avst_startofpacket, 1'b0);
        chk("rst_eop", bus.avst_endofpacket, 1'b0);
        chk("rst_err", bus.avst_error, 1'b0);
        chk("rst_empty", bus.avst_empty, 3'd0);
        chk("rst_data", bus.avst_data, 64'd0);
        chk("rst_tready", bus.s_axis_tready, 2'b00);
        chk("rst_grant", bus.grant_port, 1'b0);
        rst_n = 1'b1;

        // Two ports collide: port 0 then port 1, back to back, then wrap.
        chk_grant = 1'b1;
        sop_ports.delete();
        any_acc = 1'b0;
        add_pkt(0, 2, 64'h0A00, 8'hFF, 1'b0);
        add_pkt(1, 2, 64'h0B00, 8'hFF, 1'b0);
        run(200);
        chk("t2_no_bubble_a", last_acc - first_acc, 3);
        any_acc = 1'b0;
        add_pkt(0, 2, 64'h0C00, 8'hFF, 1'b0);
        add_pkt(1, 2, 64'h0D00, 8'hFF, 1'b0);
        run(200);
        chk("t2_no_bubble_b", last_acc - first_acc, 3);
        chk("t2_npkts", sop_ports.size(), 4);
        if (sop_ports.size() == 4) begin
            chk("t2_order0", sop_ports[0], 0);
            chk("t2_order1", sop_ports[1], 1);
            chk("t2_order2", sop_ports[2], 0);
            chk("t2_order3", sop_ports[3], 1);
        end
        chk_grant = 1'b0;

        // Three-beat packet, last keep 0x07.
        obs.delete();
        add_beat(0, 64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0);
        add_beat(0, 64'h2222_2222_2222_2222, 8'hFF, 1'b0, 1'b0);
        add_beat(0, 64'h3333_3333_3333_3333, 8'h07, 1'b1, 1'b0);
        run(200);
        chk("t1_nbeats", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("t1_b0", {obs[0].data, obs[0].sop, obs[0].eop, obs[0].empty,
                          obs[0].err},
                {64'h1111_1111_1111_1111, 1'b1, 1'b0, 3'd0, 1'b0});
            chk("t1_b1", {obs[1].data, obs[1].sop, obs[1].eop, obs[1].empty,
                          obs[1].err},
                {64'h2222_2222_2222_2222, 1'b0, 1'b0, 3'd0, 1'b0});
            chk("t1_b2", {obs[2].data, obs[2].sop, obs[2].eop, obs[2].empty,
                          obs[2].err},
                {64'h3333_3333_3333_3333, 1'b0, 1'b1, 3'd5, 1'b0});
        end

        // tuser on every beat only reaches error on the eop beat.
        obs.delete();
        add_pkt(1, 2, 64'h4400, 8'hFF, 1'b1);
        run(200);
        chk("t4_nbeats", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("t4_err_b0", obs[0].err, 1'b0);
            chk("t4_err_b1", {obs[1].err, obs[1].eop}, 2'b11);
        end

        for (int i = 0; i < 7; i++) begin
            obs.delete();
            add_beat(tbl[i].port, tbl[i].data, tbl[i].keep, 1'b1, tbl[i].user);
            run(200);
            chk($sformatf("tbl%0d_n", i), obs.size(), 1);
            if (obs.size() == 1)
                chk($sformatf("tbl%0d", i),
                    {obs[0].data, obs[0].sop, obs[0].eop, obs[0].empty,
                     obs[0].err},
                    {tbl[i].data, 1'b1, 1'b1, tbl[i].x_empty, tbl[i].x_err});
        end

        // Port 0 arrives while port 1 is mid-packet; it must wait.
        sop_ports.delete();
        add_pkt(1, 6, 64'h6100, 8'hFF, 1'b0);
        add_pkt(1, 2, 64'h6200, 8'hFF, 1'b0);
        repeat (3) step();
        add_pkt(0, 2, 64'h6000, 8'hFF, 1'b0);
        step();
        chk("t6_tvalid0", bus.s_axis_tvalid[0], 1'b1);
        chk("t6_tready0", bus.s_axis_tready[0], 1'b0);
        run(300);
        chk("t6_npkts", sop_ports.size(), 3);
        if (sop_ports.size() == 3) begin
            chk("t6_order0", sop_ports[0], 1);
            chk("t6_order1", sop_ports[1], 0);
            chk("t6_order2", sop_ports[2], 1);
        end

        // Three-cycle sink stall in mid-packet.
        obs.delete();
        add_pkt(0, 8, 64'h3000, 8'hFF, 1'b0);
        repeat (3) step();
        rdy_prob = 0;
        repeat (3) step();
        chk("t3_tvalid", bus.s_axis_tvalid[0], 1'b1);
        chk("t3_tready_low", bus.s_axis_tready[0], 1'b0);
        rdy_prob = 100;
        run(300);
        chk("t3_nbeats", obs.size(), 8);
        if (obs.size() == 8)
            for (int k = 0; k < 8; k++)
                chk($sformatf("t3_data%0d", k), obs[k].data, 64'h3000 + k);

        // Reset pulse in the middle of a 4-beat packet.
        add_pkt(0, 4, 64'h5000, 8'hFF, 1'b0);
        repeat (3) step();
        chk("t5_pre_valid", bus.avst_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", bus.avst_valid, 1'b0);
        chk("t5_rst_tready", bus.s_axis_tready, 2'b00);
        chk("t5_rst_sop", bus.avst_startofpacket, 1'b0);
        clear_model();
        obs.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add_beat(1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b0);
        run(200);
        chk("t5_nbeats", obs.size(), 1);
        if (obs.size() == 1)
            chk("t5_beat", {obs[0].data, obs[0].sop, obs[0].eop, obs[0].empty},
                {64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 3'd0});

        // Random traffic against the scoreboard.
        vld_prob = 70;
        rdy_prob = 70;
        for (int n = 0; n < 300; n++) begin
            int p;
            int len;
            int nb;
            p   = int'($urandom_range(P - 1));
            len = int'($urandom_range(5, 1));
            nb  = int'($urandom_range(8, 1));
            for (int k = 0; k < len; k++)
                add_beat(p, {$urandom, $urandom},
                         (k == len - 1) ? 8'((1 << nb) - 1) : 8'($urandom),
                         k == len - 1, 1'($urandom));
        end
        run(30000);
        vld_prob = 100;
        rdy_prob = 100;
        repeat (3) step();
        chk("final_idle", bus.avst_valid, 1'b0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
